// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, fixed-latency memory between the PipeCPU fetch (I)
// and data (D) ports. D has priority. A starvation guard forces an I grant.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LATENCY    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_valid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam int SC_W  = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [SC_W-1:0]   starve_cnt, starve_nx;
  logic              owner_d, owner_d_nx;
  logic              txn_we, txn_we_nx;

  logic              mem_en_nx, mem_we_nx, i_valid_nx, d_valid_nx, busy_nx;
  logic [ADDR_W-1:0] mem_addr_nx;
  logic [DATA_W-1:0] mem_wdata_nx, i_rdata_nx, d_rdata_nx, rdata_word;
  logic              any_req, starving, grant_i;

  assign any_req    = i_req | d_req;
  assign starving   = (starve_cnt == SC_W'(STARVE_MAX));
  assign grant_i    = i_req & (~d_req | starving);
  assign rdata_word = txn_we ? '0 : mem_rdata;
  assign busy_nx    = (state_nx != IDLE);

  always_comb begin
    // NOTE: every *_nx gets a default before the case, so no path infers a latch.
    state_nx     = state;
    cnt_nx       = cnt;
    owner_d_nx   = owner_d;
    txn_we_nx    = txn_we;
    mem_en_nx    = 1'b0;
    mem_we_nx    = 1'b0;
    mem_addr_nx  = mem_addr;
    mem_wdata_nx = mem_wdata;
    i_valid_nx   = 1'b0;
    d_valid_nx   = 1'b0;
    i_rdata_nx   = i_rdata;
    d_rdata_nx   = d_rdata;

    unique case (state)
      IDLE: begin
        if (any_req) begin
          state_nx  = WAIT;
          cnt_nx    = CNT_W'(LATENCY);
          mem_en_nx = 1'b1;
          if (grant_i) begin
            owner_d_nx   = 1'b0;
            txn_we_nx    = 1'b0;
            mem_addr_nx  = i_addr;
            mem_wdata_nx = '0;
          end else begin
            owner_d_nx   = 1'b1;
            txn_we_nx    = d_we;
            mem_we_nx    = d_we;
            mem_addr_nx  = d_addr;
            mem_wdata_nx = d_wdata;
          end
        end
      end
      WAIT: begin
        // cnt hits zero exactly in the cycle the memory presents its data.
        if (cnt == '0) begin
          state_nx = DONE;
          if (owner_d) begin
            d_valid_nx = 1'b1;
            d_rdata_nx = rdata_word;
          end else begin
            i_valid_nx = 1'b1;
            i_rdata_nx = rdata_word;
          end
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Counts D grants made while I is waiting; any idle cycle of i_req forgives.
  always_comb begin
    starve_nx = starve_cnt;
    if (!i_req) begin
      starve_nx = '0;
    end else if (state == IDLE) begin
      if (grant_i) begin
        starve_nx = '0;
      end else if (!starving) begin
        starve_nx = starve_cnt + SC_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      starve_cnt <= '0;
      owner_d    <= 1'b0;
      txn_we     <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      i_valid    <= 1'b0;
      i_rdata    <= '0;
      d_valid    <= 1'b0;
      d_rdata    <= '0;
      busy       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state      <= state_nx;
      cnt        <= cnt_nx;
      starve_cnt <= starve_nx;
      owner_d    <= owner_d_nx;
      txn_we     <= txn_we_nx;
      mem_en     <= mem_en_nx;
      mem_we     <= mem_we_nx;
      mem_addr   <= mem_addr_nx;
      mem_wdata  <= mem_wdata_nx;
      i_valid    <= i_valid_nx;
      i_rdata    <= i_rdata_nx;
      d_valid    <= d_valid_nx;
      d_rdata    <= d_rdata_nx;
      busy       <= busy_nx;
    end
  end

  // Protocol invariants.
  a_valid_exclusive : assert property (@(posedge clock) disable iff (reset)
    !(i_valid && d_valid));
  a_en_single_cycle : assert property (@(posedge clock) disable iff (reset)
    mem_en |=> !mem_en);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Sequences a single-ported, fixed-latency unified memory shared by the PipeCPU instruction-fetch port (I) and data-memory port (D). Picks one requester per transaction, drives the memory command for one cycle, waits LATENCY cycles, then returns data to the winner with a one-cycle valid pulse. D has priority over I, with a starvation guard that forces an I grant after STARVE_MAX consecutive D grants. Sits between PipeCPU and the memory model inside PipeSystem.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data word width
LATENCY, 2, cycles from the mem_en cycle to the cycle mem_rdata is valid (>=1)
STARVE_MAX, 4, consecutive D grants allowed while I waits (>=1)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
i_req  in  1  fetch request, level; held until i_valid
i_addr  in  ADDR_W  fetch address
i_valid  out  1  one-cycle pulse, fetch data ready
i_rdata  out  DATA_W  fetched word, meaningful when i_valid
d_req  in  1  data request, level; held until d_valid
d_we  in  1  1 = write, 0 = read
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_valid  out  1  one-cycle pulse, data access complete
d_rdata  out  DATA_W  read word; 0 for writes
mem_en  out  1  memory command strobe, one cycle per transaction
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid LATENCY cycles after mem_en
busy  out  1  1 when state != IDLE

Behaviour:
- All outputs are registered. Reset drives every output to 0, state to IDLE, and the latency and starvation counters to 0.
- States: IDLE, WAIT, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Otherwise, at the clock edge pick a winner, latch its owner, addr, we and wdata, and move to WAIT.
  - In the first WAIT cycle: mem_en=1, mem_we=we (0 for I), mem_addr/mem_wdata=latched values; cnt=LATENCY.
- Arbitration:
  - D wins, unless i_req=1 and starve_cnt==STARVE_MAX, in which case I wins.
  - starve_cnt increments on a D grant while i_req=1.
  - starve_cnt clears on an I grant, or on any cycle with i_req=0.
  - starve_cnt saturates at STARVE_MAX.
- WAIT:
  - mem_en is high in the first WAIT cycle only; mem_we follows mem_en; mem_addr/mem_wdata hold their values.
  - cnt decrements each cycle. When cnt reaches 0, which is the cycle mem_en+LATENCY, capture mem_rdata (0 for writes) and move to DONE.
- DONE (one cycle):
  - Owner's x_valid=1 and x_rdata=captured word; the other port's valid stays 0. Next state is IDLE.
  - Requests are not sampled in DONE. This prevents re-granting a still-asserted, already-served request.
- rdata outputs hold their last value after the valid pulse.
- Timing with a request first seen in IDLE cycle t: mem_en at t+1, valid at t+2+LATENCY. Minimum spacing between mem_en pulses is LATENCY+3 cycles.
- Addresses and data pass unmodified; there is no alignment check.
- Request inputs that change while the arbiter is not in IDLE are ignored. Only the values latched at grant are used.
- Reset mid-transaction: outputs go to 0 immediately. Any mem_rdata arriving after reset is discarded, and no valid pulse is produced.
- Both valids are never high together. mem_en is never high for two consecutive cycles.

Test Plan:
1. LATENCY=2. i_req=1, i_addr=0x00400000 from cycle 0; memory returns 0x2008000A in cycle 3 -> mem_en=1 only in cycle 1 with mem_addr=0x00400000 and mem_we=0; i_valid=1 only in cycle 4 with i_rdata=0x2008000A; busy=1 in cycles 1-4.
2. Both requests raised in cycle 0: i_addr=0x00400004, d_addr=0x10010000 (read) -> D gets mem_en in cycle 1 and d_valid in cycle 4; I gets mem_en in cycle 6 and i_valid in cycle 9; the valids never overlap.
3. d_req=1, d_we=1, d_addr=0x10010008, d_wdata=0xDEADBEEF -> one cycle with mem_en=mem_we=1, mem_addr=0x10010008, mem_wdata=0xDEADBEEF; d_valid pulses 3 cycles later with d_rdata=0.
4. STARVE_MAX=4, i_req and d_req both held high, each requester re-arming after its valid -> grant order D,D,D,D,I,D,... and starve_cnt returns to 0 after the I grant.
5. Reset asserted for 1 cycle in the cycle after mem_en of a D read -> all outputs read 0 immediately; no d_valid appears even though memory drives data in the expected cycle; the next request starts a fresh transaction from IDLE.
6. Back-to-back I fetches: i_req held and i_addr advanced by 4 after each i_valid -> mem_en pulses exactly 5 cycles apart at LATENCY=2, addresses in order, and no duplicate grant for the address already served.
